// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants used by the fetch stage
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam logic [4:0]  EXC_ADEL = 5'h04;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: one SRAM-like request per PC, result held in a valid/ready register
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_ena,
  input  logic             flush,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_inst,
  output logic             id_adel
);

  fetch_state_t state;
  logic         cancel;
  logic         misaligned;
  logic         rst_q;

  assign misaligned = (pc[1:0] != 2'b00);
  assign inst_addr  = pc;
  assign inst_req   = (state == S_REQ) && !misaligned && !flush;

  // The PC may only move once its instruction is captured, faulted, or redirected.
  always_comb begin
    pc_ena = 1'b0;
    case (state)
      S_REQ:   pc_ena = flush || misaligned;
      S_WAIT:  pc_ena = flush || (inst_data_ok && !cancel);
      S_HOLD:  pc_ena = flush;
      default: pc_ena = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      cancel   <= 1'b0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
      id_adel  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!flush) begin
            if (misaligned) begin
              id_pc    <= pc;
              id_inst  <= '0;
              id_adel  <= 1'b1;
              id_valid <= 1'b1;
              state    <= S_HOLD;
            end else if (inst_addr_ok) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            cancel <= 1'b0;
            if (flush || cancel) begin
              state <= S_REQ;
            end else begin
              id_pc    <= pc;
              id_inst  <= inst_rdata;
              id_adel  <= 1'b0;
              id_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (flush) begin
            // Response still owed by the SRAM; remember to drop it.
            cancel <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush || id_ready) begin
            id_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (!rst && rst_q == 1'b1) begin
      assert (pc == RESET_PC);
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current PC and issues one request per instruction on an SRAM-like instruction port (addr_ok/data_ok handshake).
- Returns the fetched word to decode through a valid/ready output register.
- Generates the PC register's enable, so the PC advances only after its instruction has been captured or the stage is flushed.

Parameters:
- WIDTH, 32, address and instruction width.
- RESET_PC, 32'hbfc0_0000, expected PC after reset; used only by benches and assertions, not by the logic.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  in  WIDTH  current PC from the PC register.
- pc_ena  out  1  enable to the PC register; it loads npc on the next edge.
- flush  in  1  redirect from a later stage; the external npc mux selects the target while flush is high.
- inst_req  out  1  instruction request.
- inst_addr  out  WIDTH  request address; always equals pc.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  WIDTH  read data.
- id_valid  out  1  decode-side output valid.
- id_ready  in  1  decode accepts this cycle.
- id_pc  out  WIDTH  PC of the held instruction.
- id_inst  out  WIDTH  held instruction word.
- id_adel  out  1  address-error-on-fetch flag; set when pc[1:0] != 0.

Behaviour:
- The design has one clock and synchronous active-high reset. Port names are clk and rst.
- Reset values:
  - state = S_REQ, cancel = 0, id_valid = 0, id_pc = 0, id_inst = 0, id_adel = 0.
  - The PC register resets in the same cycle, so the first request after reset is to 32'hbfc0_0000.
- misaligned = (pc[1:0] != 0).
- S_REQ:
  - inst_req = !misaligned && !flush.
  - flush → stay in S_REQ, pc_ena = 1.
  - misaligned && !flush → no request. Load id_pc = pc, id_inst = 0, id_adel = 1, id_valid = 1. pc_ena = 1. Go to S_HOLD.
  - inst_req && inst_addr_ok → go to S_WAIT.
  - Otherwise hold inst_req high with a stable address.
- S_WAIT:
  - inst_req = 0.
  - inst_data_ok && !cancel → capture id_pc = pc, id_inst = inst_rdata, id_adel = 0, id_valid = 1. pc_ena = 1. Go to S_HOLD.
  - flush (no data_ok, or data_ok this same cycle) → pc_ena = 1.
    - With no data_ok, set cancel and stay in S_WAIT.
    - If data_ok arrives in the same cycle, discard the data and go to S_REQ.
  - inst_data_ok && cancel → discard the data, clear cancel, go to S_REQ.
- S_HOLD:
  - Outputs stay stable while id_valid && !id_ready.
  - id_ready && !flush → clear id_valid, go to S_REQ.
  - flush → clear id_valid, pc_ena = 1, go to S_REQ. Flush beats a simultaneous id_ready; decode is flushed too, so that transfer is void.
- pc_ena is combinational. It is never high for more than one cycle per captured instruction, except during consecutive flushes.
- inst_addr is unregistered and equals pc.
- The fetched instruction reaches id_valid 1 cycle after data_ok. Best-case throughput is one instruction per 3 cycles.
- inst_data_ok outside S_WAIT, including stray responses after a reset mid-transaction, is ignored.
- Reset mid-operation: return to reset values immediately; any in-flight response is dropped.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum: S_REQ, S_WAIT, S_HOLD.
  - RESET_PC constant 32'hbfc0_0000.
  - EXC_ADEL = 5'h04.
- No sub-module; a single FSM plus output register.

Test Plan:
- Reset release → cycle 1: inst_req = 1, inst_addr = 32'hbfc0_0000, id_valid = 0, pc_ena = 0.
- addr_ok after 2 cycles, then data_ok 1 cycle later with rdata = 32'h2408_0001 → one pc_ena pulse on the data_ok cycle. Next cycle: id_valid = 1, id_pc = 32'hbfc0_0000, id_inst = 32'h2408_0001.
- id_ready low for 3 cycles in S_HOLD → id_* stable, inst_req = 0, pc_ena = 0. id_ready high → id_valid = 0 next cycle, then inst_req at 32'hbfc0_0004.
- flush in S_WAIT with npc = 32'hbfc0_0100, data_ok 2 cycles later with 32'hdead_beef → data dropped, id_valid stays 0, next inst_addr = 32'hbfc0_0100.
- pc = 32'hbfc0_0002 → no inst_req. Next cycle: id_valid = 1, id_adel = 1, id_inst = 0, id_pc = 32'hbfc0_0002.
- rst asserted in S_WAIT, data_ok arrives after release → state S_REQ, id_valid = 0, response ignored, fresh request to 32'hbfc0_0000.
